// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
// Imported by the arbiter top and its round-robin picker.
package mem_arb_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC0 = 2'd1,
        ACC1 = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Two-way round-robin grant: with a single eligible request it wins outright;
// with both eligible, the requester named by prio_i wins.
module rr_pick (
    input  logic elig0_i,
    input  logic elig1_i,
    input  logic prio_i,
    output logic grant0_o,
    output logic grant1_o
);

    assign grant0_o = elig0_i & (~elig1_i | ~prio_i);
    assign grant1_o = elig1_i & (~elig0_i |  prio_i);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a single-port RAM between a CPU (port 0) and a loader/DMA (port 1).
// Each access takes one IDLE arbitration cycle plus one RAM cycle; ack follows.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wd0,
    input  logic [DATA_W-1:0] wd1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    arb_state_e        state_q, state_d;
    logic              prio_q, prio_d;
    logic              ack0_q, ack0_d;
    logic              ack1_q, ack1_d;
    logic              weLat_q, weLat_d;
    logic [ADDR_W-1:0] addrLat_q, addrLat_d;
    logic [DATA_W-1:0] wdLat_q, wdLat_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;
    logic [DATA_W-1:0] rdata1_q, rdata1_d;

    logic elig0, elig1;
    logic grant0, grant1;

    // A requester being acked this cycle still holds req high; masking it
    // here prevents a second grant for the same request.
    assign elig0 = req0 & ~ack0_q;
    assign elig1 = req1 & ~ack1_q;

    rr_pick u_rr_pick (
        .elig0_i  (elig0),
        .elig1_i  (elig1),
        .prio_i   (prio_q),
        .grant0_o (grant0),
        .grant1_o (grant1)
    );

    always_comb begin
        state_d   = state_q;
        prio_d    = prio_q;
        ack0_d    = 1'b0;
        ack1_d    = 1'b0;
        weLat_d   = weLat_q;
        addrLat_d = addrLat_q;
        wdLat_d   = wdLat_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;

        unique case (state_q)
            IDLE: begin
                if (grant0) begin
                    state_d   = ACC0;
                    prio_d    = 1'b1;
                    weLat_d   = we0;
                    addrLat_d = addr0;
                    wdLat_d   = wd0;
                end else if (grant1) begin
                    state_d   = ACC1;
                    prio_d    = 1'b0;
                    weLat_d   = we1;
                    addrLat_d = addr1;
                    wdLat_d   = wd1;
                end
            end
            ACC0: begin
                state_d  = IDLE;
                rdata0_d = mem_rd;
                ack0_d   = 1'b1;
            end
            ACC1: begin
                state_d  = IDLE;
                rdata1_d = mem_rd;
                ack1_d   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            prio_q    <= 1'b0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            weLat_q   <= 1'b0;
            addrLat_q <= '0;
            wdLat_q   <= '0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            state_q   <= state_d;
            prio_q    <= prio_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            weLat_q   <= weLat_d;
            addrLat_q <= addrLat_d;
            wdLat_q   <= wdLat_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
        end
    end

    // The RAM address and data stay parked on the last latched access so the
    // RAM sees no spurious toggles between accesses.
    assign mem_we   = weLat_q & ((state_q == ACC0) | (state_q == ACC1));
    assign mem_addr = addrLat_q;
    assign mem_wd   = wdLat_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign rdata0   = rdata0_q;
    assign rdata1   = rdata1_q;

endmodule
